// File: rtl/out_pkg.sv
// Shared constants and types for the LED output scan controller.
package out_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int DIG_W      = 3;
   localparam int VAL_W      = 4;

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } scan_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: req[0]/gnt[0] is the CPU port, req[1]/gnt[1]
// the debug port. On a tie the port that did not win most recently is granted.
module rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // 1 = port 1 (debug) won last; resets to debug so the CPU wins the first tie.
   logic last_q, last_d;

   // Grant selection and last-winner update; nothing is granted while in reset.
   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      if (!reset) begin
         if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
         else              gnt = req;
      end
      if (gnt[0])      last_d = 1'b0;
      else if (gnt[1]) last_d = 1'b1;
   end

   // Last-winner pointer register.
   always_ff @(posedge clock) begin
      if (reset) last_q <= 1'b1;
      else       last_q <= last_d;
   end

endmodule

// File: rtl/out_scan_ctrl.sv
// Digit scan controller and shared digit-value buffer for the 8-digit LED block.
// Optional anti-ghosting blank gap between digits: define OUT_SCAN_BLANK_EN.
module out_scan_ctrl
   import out_pkg::*;
#(
   parameter int DWELL     = 1024,
   parameter int BLANK_CYC = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic [DIG_W-1:0] cpu_digit,
   input  logic [VAL_W-1:0] cpu_val,
   input  logic             dbg_req,
   input  logic [DIG_W-1:0] dbg_digit,
   input  logic [VAL_W-1:0] dbg_val,
   output logic             cpu_gnt,
   output logic             dbg_gnt,
   output logic [DIG_W-1:0] sel,
   output logic [VAL_W-1:0] digit_val,
   output logic             blank,
   output logic             frame_tick
);

   // One counter serves both the dwell and the blank interval.
   localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
`ifdef OUT_SCAN_BLANK_EN
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif
   localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);

   scan_state_t                        state_q, state_d;
   logic [CNT_W-1:0]                   cnt_q, cnt_d;
   logic [DIG_W-1:0]                   sel_q, sel_d;
   logic                               tick_q, tick_d;
   logic [NUM_DIGITS-1:0][VAL_W-1:0]   buf_q;
   logic [1:0]                         gnt;

   rr_arb2 u_arb (
      .clock (clock),
      .reset (reset),
      .req   ({dbg_req, cpu_req}),
      .gnt   (gnt)
   );

   assign cpu_gnt    = gnt[0];
   assign dbg_gnt    = gnt[1];
   assign sel        = sel_q;
   assign digit_val  = buf_q[sel_q];
   assign frame_tick = tick_q;
`ifdef OUT_SCAN_BLANK_EN
   assign blank      = (state_q == BLANK);
`else
   assign blank      = 1'b0;
`endif

   // Scan FSM next state: advance sel after the dwell (and blank gap, if built in);
   // frame_tick is raised for the cycle that re-enters digit 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      sel_d   = sel_q;
      tick_d  = 1'b0;
      case (state_q)
         SHOW: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d = '0;
`ifdef OUT_SCAN_BLANK_EN
               state_d = BLANK;
`else
               sel_d  = sel_q + DIG_W'(1);
               tick_d = (sel_q == LAST_DIGIT);
`endif
            end
         end
`ifdef OUT_SCAN_BLANK_EN
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               cnt_d   = '0;
               sel_d   = sel_q + DIG_W'(1);
               tick_d  = (sel_q == LAST_DIGIT);
               state_d = SHOW;
            end
         end
`endif
         default: begin
            state_d = SHOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Scan state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= SHOW;
         cnt_q   <= '0;
         sel_q   <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         tick_q  <= tick_d;
      end
   end

   // Digit buffer: the granted requester writes on the edge closing its grant cycle.
   always_ff @(posedge clock) begin
      if (reset)        buf_q <= '0;
      else if (gnt[0])  buf_q[cpu_digit] <= cpu_val;
      else if (gnt[1])  buf_q[dbg_digit] <= dbg_val;
   end

endmodule

// File: tb/tb_out_scan_ctrl.sv
// Bench for out_scan_ctrl (DWELL=4, BLANK_CYC=2); follows OUT_SCAN_BLANK_EN if defined.
module tb_out_scan_ctrl;

   localparam int DW = 4;
   localparam int BC = 2;
`ifdef OUT_SCAN_BLANK_EN
   localparam bit BEN = 1'b1;
   localparam int P   = DW + BC;
   localparam int TGT = DW;       // first blank cycle of a digit
`else
   localparam bit BEN = 1'b0;
   localparam int P   = DW;
   localparam int TGT = DW - 2;   // middle of a dwell
`endif

   logic       clock, reset;
   logic       cpu_req, dbg_req;
   logic [2:0] cpu_digit, dbg_digit;
   logic [3:0] cpu_val, dbg_val;
   logic       cpu_gnt, dbg_gnt;
   logic [2:0] sel;
   logic [3:0] digit_val;
   logic       blank, frame_tick;

   out_scan_ctrl #(.DWELL(DW), .BLANK_CYC(BC)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_digit(cpu_digit), .cpu_val(cpu_val),
      .dbg_req(dbg_req), .dbg_digit(dbg_digit), .dbg_val(dbg_val),
      .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt),
      .sel(sel), .digit_val(digit_val), .blank(blank), .frame_tick(frame_tick)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit         who;   // 0 = cpu, 1 = dbg
      logic [2:0] d;
      logic [3:0] v;
   } wr_t;

   typedef struct {
      int         k;
      logic [2:0] s;
      bit         b;
      bit         t;
   } vec_t;

   int         total = 0;
   int         bad   = 0;
   wr_t        q[$];
   vec_t       vt[$];
   int         kk = 0;
   bit         rst_seen = 1'b0;
   logic [3:0] mb[8];
   bit         pend_v = 1'b0;
   wr_t        pend;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wr(input bit who, input logic [2:0] d, input logic [3:0] v);
      wr_t it;
      bit  got;
      it = '{who, d, v};
      q.push_back(it);
      @(posedge clock); #1;
      if (who) begin dbg_req = 1'b1; dbg_digit = d; dbg_val = v; end
      else     begin cpu_req = 1'b1; cpu_digit = d; cpu_val = v; end
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         got = who ? dbg_gnt : cpu_gnt;
      end
      chk("wr_gnt", 32'(got), 32'd1);
      @(posedge clock); #1;
      cpu_req = 1'b0; dbg_req = 1'b0;
      @(negedge clock);
      chk("gnt_one_cycle", 32'(who ? dbg_gnt : cpu_gnt), 32'd0);
   endtask

   task automatic wait_sel(input logic [2:0] s);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clock);
         found = (sel == s);
      end
      chk("wait_sel", 32'(found), 32'd1);
   endtask

   initial begin
      reset = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;
      cpu_digit = '0; dbg_digit = '0; cpu_val = '0; dbg_val = '0;
      for (int i = 0; i < 8; i++) mb[i] = 4'h0;

      fork
         // Reference timeline and buffer model, advanced on every rising edge.
         forever begin
            @(posedge clock);
            if (reset) begin
               kk = 0;
               rst_seen = 1'b1;
               for (int i = 0; i < 8; i++) mb[i] = 4'h0;
            end else begin
               kk++;
               if (pend_v) mb[pend.d] = pend.v;
            end
         end
         // Monitor: scan outputs every cycle, grants popped from the scoreboard.
         forever begin
            logic [2:0] es;
            bit         eb, et;
            wr_t        it;
            @(negedge clock);
            if (rst_seen) begin
               es = 3'((kk / P) % 8);
               eb = BEN && ((kk % P) >= DW);
               et = (kk > 0) && ((kk % (8 * P)) == 0);
               chk("scan", 32'({sel, blank, frame_tick, digit_val}),
                           32'({es, eb, et, mb[es]}));
            end
            pend_v = 1'b0;
            if (cpu_gnt || dbg_gnt) begin
               chk("gnt_onehot", 32'(cpu_gnt & dbg_gnt), 32'd0);
               if (q.size() == 0) begin
                  chk("spurious_gnt", 32'({cpu_gnt, dbg_gnt}), 32'd0);
               end else begin
                  it = q.pop_front();
                  chk("gnt_who", 32'(dbg_gnt), 32'(it.who));
                  pend   = it;
                  pend_v = 1'b1;
               end
            end
         end
      join_none

      // Reset state; a request during reset must not be granted.
      repeat (2) @(posedge clock);
      #1 cpu_req = 1'b1; cpu_digit = 3'd1; cpu_val = 4'h9;
      @(negedge clock);
      chk("rst_sel",   32'(sel),        32'd0);
      chk("rst_blank", 32'(blank),      32'd0);
      chk("rst_tick",  32'(frame_tick), 32'd0);
      chk("rst_val",   32'(digit_val),  32'd0);
      chk("rst_gnt",   32'(cpu_gnt),    32'd0);
      @(posedge clock); #1;
      reset = 1'b0; cpu_req = 1'b0;

      // Hand-computed scan points (cycles counted from reset release).
`ifdef OUT_SCAN_BLANK_EN
      vt.push_back('{3,  3'd0, 1'b0, 1'b0});
      vt.push_back('{4,  3'd0, 1'b1, 1'b0});
      vt.push_back('{5,  3'd0, 1'b1, 1'b0});
      vt.push_back('{6,  3'd1, 1'b0, 1'b0});
      vt.push_back('{47, 3'd7, 1'b1, 1'b0});
      vt.push_back('{48, 3'd0, 1'b0, 1'b1});
      vt.push_back('{49, 3'd0, 1'b0, 1'b0});
`else
      vt.push_back('{3,  3'd0, 1'b0, 1'b0});
      vt.push_back('{4,  3'd1, 1'b0, 1'b0});
      vt.push_back('{31, 3'd7, 1'b0, 1'b0});
      vt.push_back('{32, 3'd0, 1'b0, 1'b1});
      vt.push_back('{33, 3'd0, 1'b0, 1'b0});
`endif
      foreach (vt[n]) begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clock);
            hit = (kk == vt[n].k);
         end
         chk("vec_reach", 32'(hit), 32'd1);
         chk("vec_sel",   32'(sel),        32'(vt[n].s));
         chk("vec_blank", 32'(blank),      32'(vt[n].b));
         chk("vec_tick",  32'(frame_tick), 32'(vt[n].t));
      end

      // Single-requester writes, then read back while scanning.
      wr(1'b0, 3'd3, 4'hA);
      wr(1'b1, 3'd5, 4'h7);
      wait_sel(3'd3);
      chk("sel3_val", 32'(digit_val), 32'hA);
      wait_sel(3'd5);
      chk("sel5_val", 32'(digit_val), 32'h7);

      // Both requesters held for 4 cycles: CPU, DBG, CPU, DBG.
      q.push_back('{1'b0, 3'd1, 4'h1});
      q.push_back('{1'b1, 3'd2, 4'h2});
      q.push_back('{1'b0, 3'd1, 4'h1});
      q.push_back('{1'b1, 3'd2, 4'h2});
      @(posedge clock); #1;
      cpu_req = 1'b1; cpu_digit = 3'd1; cpu_val = 4'h1;
      dbg_req = 1'b1; dbg_digit = 3'd2; dbg_val = 4'h2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("tie_cpu", 32'(cpu_gnt), 32'((i % 2) == 0));
         chk("tie_dbg", 32'(dbg_gnt), 32'((i % 2) == 1));
      end
      @(posedge clock); #1;
      cpu_req = 1'b0; dbg_req = 1'b0;

      // Write digit 0 while it is displayed: visible on the next cycle.
      begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clock); #1;
            hit = ((kk % (8 * P)) == 0);
         end
         chk("frame_start", 32'(hit), 32'd1);
      end
      q.push_back('{1'b0, 3'd0, 4'hF});
      cpu_req = 1'b1; cpu_digit = 3'd0; cpu_val = 4'hF;
      @(negedge clock);
      chk("f_gnt", 32'(cpu_gnt), 32'd1);
      @(posedge clock); #1;
      cpu_req = 1'b0;
      @(negedge clock);
      chk("f_sel0", 32'(sel),       32'd0);
      chk("f_show", 32'(digit_val), 32'hF);

      // Reset mid-blank (mid-dwell without the gap) with requests pending.
      begin
         bit hit;
         hit = 1'b0;
         for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clock); #1;
            hit = ((kk % P) == TGT) && (((kk / P) % 8) == 3);
         end
         chk("rst_point", 32'(hit), 32'd1);
      end
      reset = 1'b1;
      cpu_req = 1'b1; cpu_digit = 3'd3; cpu_val = 4'h5;
      dbg_req = 1'b1; dbg_digit = 3'd4; dbg_val = 4'h6;
      @(negedge clock);
      chk("mid_rst_gnt",   32'({cpu_gnt, dbg_gnt}), 32'd0);
      chk("mid_rst_blank", 32'(blank),              32'(BEN));
      @(posedge clock); #1;
      reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
      @(negedge clock);
      chk("post_rst_sel",   32'(sel),       32'd0);
      chk("post_rst_val",   32'(digit_val), 32'd0);
      chk("post_rst_blank", 32'(blank),     32'd0);
      begin
         int nz;
         nz = 0;
         for (int i = 0; i < 8 * P + 2; i++) begin
            @(negedge clock);
            if (digit_val != 4'h0) nz++;
         end
         chk("post_rst_clear", 32'(nz), 32'd0);
      end

      chk("q_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
